// File: rtl/bram_sp_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous BRAM.
// Combinational grant with a burst limit; read responses come back one cycle later.
module bram_sp_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_gnt,
    output logic                  a_rd_valid,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic                  b_gnt,
    output logic                  b_rd_valid,
    output logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  bram_wr,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } acc_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lst, lst_nxt;   // last served: 0 = A, 1 = B
    acc_t          acc;
    logic [1:0]    rv_q;           // {B, A} read issued last cycle

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        state_nxt = IDLE;
        cnt_nxt   = '0;
        lst_nxt   = lst;
        acc       = '0;
        if (rst_n) begin
            case (state)
                OWN_A: begin
                    if (a_req && (cnt < MAXC || !b_req)) a_gnt = 1'b1;
                    else if (b_req)                      b_gnt = 1'b1;
                end
                OWN_B: begin
                    if (b_req && (cnt < MAXC || !a_req)) b_gnt = 1'b1;
                    else if (a_req)                      a_gnt = 1'b1;
                end
                default: begin
                    if (a_req && (!b_req || lst)) a_gnt = 1'b1;
                    else if (b_req)               b_gnt = 1'b1;
                end
            endcase
        end
        // Owner re-grant at the limit with no contender restarts the burst at 1.
        if (a_gnt) begin
            state_nxt = OWN_A;
            cnt_nxt   = (state == OWN_A && cnt < MAXC) ? cnt + 1'b1 : CW'(1);
            lst_nxt   = 1'b0;
            acc       = '{wr: a_wr, addr: a_addr, din: a_din};
        end else if (b_gnt) begin
            state_nxt = OWN_B;
            cnt_nxt   = (state == OWN_B && cnt < MAXC) ? cnt + 1'b1 : CW'(1);
            lst_nxt   = 1'b1;
            acc       = '{wr: b_wr, addr: b_addr, din: b_din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            lst   <= 1'b1;
            rv_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lst   <= lst_nxt;
            rv_q  <= {b_gnt & ~b_wr, a_gnt & ~a_wr};
        end
    end

    assign bram_wr   = acc.wr;
    assign bram_addr = acc.addr;
    assign bram_din  = acc.din;

    // Gating with rst_n drops a response whose cycle coincides with reset.
    assign a_rd_valid = rv_q[0] & rst_n;
    assign b_rd_valid = rv_q[1] & rst_n;
    assign a_rd_data  = bram_dout;
    assign b_rd_data  = bram_dout;
endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Table-driven check of bram_sp_arbiter with a behavioural BRAM and a read-response scoreboard.
module tb_bram_sp_arbiter;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic          a_gnt, a_rd_valid, b_gnt, b_rd_valid;
    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          bram_wr;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    bram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
        .a_gnt(a_gnt), .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
        .b_gnt(b_gnt), .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
        .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    // Single-port synchronous BRAM, write-first, 1-cycle read latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (bram_wr) mem[bram_addr] <= bram_din;
        bram_dout <= bram_wr ? bram_din : mem[bram_addr];
    end

    typedef struct {
        logic          rst_n;
        logic          a_req, a_wr;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_din;
        logic          b_req, b_wr;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_din;
        logic          ea, eb;
    } vec_t;

    typedef struct {
        logic          port;   // 0 = A, 1 = B
        int            cyc;
        logic [DW-1:0] data;
    } sb_t;

    vec_t          vecs[$];
    sb_t           sb[$];
    logic [DW-1:0] shadow [16];
    int            checks = 0;
    int            errors = 0;

    task automatic add(input logic r, input logic ar, input logic aw, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic br, input logic bw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic ea, input logic eb);
        vec_t v;
        v.rst_n = r; v.a_req = ar; v.a_wr = aw; v.a_addr = aa; v.a_din = ad;
        v.b_req = br; v.b_wr = bw; v.b_addr = ba; v.b_din = bd; v.ea = ea; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_wr = 0; a_addr = '0; a_din = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_din = '0;

        // rst  A: req wr addr din          B: req wr addr din         expA expB
        add(0, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);
        add(0, 1,1,4'd5,32'h77,         1,1,4'd6,32'h66,         0,0);  // gated in reset
        add(1, 0,0,4'd0,32'h0,          1,1,4'd3,32'hDEADBEEF,   0,1);  // B writes 3
        add(1, 1,0,4'd3,32'h0,          0,0,4'd0,32'h0,          1,0);  // A reads 3
        add(1, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);
        add(1, 1,0,4'd7,32'h0,          1,1,4'd7,32'h5,          0,1);  // tie, lst=A -> B
        add(1, 1,0,4'd7,32'h0,          0,0,4'd0,32'h0,          1,0);  // B dropped -> A
        add(1, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);
        add(1, 1,0,4'd3,32'h0,          0,0,4'd0,32'h0,          1,0);  // A read then reset
        add(0, 1,0,4'd3,32'h11,         1,0,4'd7,32'h22,         0,0);
        for (int k = 0; k < 8; k++)     // both held: A x4, B x4
            add(1, 1,0,4'd3,32'h11,     1,0,4'd7,32'h22,         k < 4, k >= 4);
        add(1, 1,0,4'd3,32'h11,         1,0,4'd7,32'h22,         1,0);  // back to A
        add(1, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);
        for (int k = 0; k < 10; k++)    // A alone, burst counter wraps
            add(1, 1,1,AW'(8 + k),DW'(32'h100 + k), 0,0,4'd0,32'h0, 1,0);
        add(1, 0,0,4'd0,32'h0,          1,0,4'd9,32'h0,          0,1);
        add(1, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);
        add(1, 0,0,4'd0,32'h0,          1,0,4'd7,32'h0,          0,1);
        add(1, 1,0,4'd3,32'h0,          1,0,4'd7,32'h0,          0,1);  // A waits
        add(1, 0,0,4'd0,32'h0,          1,0,4'd7,32'h0,          0,1);  // A withdraws
        add(1, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);
        add(1, 0,0,4'd0,32'h0,          0,0,4'd0,32'h0,          0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t          v;
            logic          ewr, eav, ebv;
            logic [AW-1:0] eaddr;
            logic [DW-1:0] edin, edat;
            v = vecs[i];
            @(posedge clk); #1;
            rst_n = v.rst_n;
            a_req = v.a_req; a_wr = v.a_wr; a_addr = v.a_addr; a_din = v.a_din;
            b_req = v.b_req; b_wr = v.b_wr; b_addr = v.b_addr; b_din = v.b_din;
            ewr = 1'b0; eaddr = '0; edin = '0;
            if (v.ea)      begin ewr = v.a_wr; eaddr = v.a_addr; edin = v.a_din; end
            else if (v.eb) begin ewr = v.b_wr; eaddr = v.b_addr; edin = v.b_din; end
            if ((v.ea || v.eb) && ewr) shadow[eaddr] = edin;
            else if (v.ea || v.eb) sb.push_back('{port: v.eb, cyc: i + 1, data: shadow[eaddr]});

            @(negedge clk);
            chk($sformatf("v%0d a_gnt", i), DW'(a_gnt), DW'(v.ea));
            chk($sformatf("v%0d b_gnt", i), DW'(b_gnt), DW'(v.eb));
            chk($sformatf("v%0d bram_wr", i), DW'(bram_wr), DW'(ewr));
            chk($sformatf("v%0d bram_addr", i), DW'(bram_addr), DW'(eaddr));
            chk($sformatf("v%0d bram_din", i), bram_din, edin);
            eav = 1'b0; ebv = 1'b0; edat = '0;
            if (sb.size() > 0 && sb[0].cyc == i) begin
                sb_t e;
                e = sb.pop_front();
                if (v.rst_n) begin
                    if (e.port) ebv = 1'b1; else eav = 1'b1;
                    edat = e.data;
                end
            end
            chk($sformatf("v%0d a_rd_valid", i), DW'(a_rd_valid), DW'(eav));
            chk($sformatf("v%0d b_rd_valid", i), DW'(b_rd_valid), DW'(ebv));
            if (eav) chk($sformatf("v%0d a_rd_data", i), a_rd_data, edat);
            if (ebv) chk($sformatf("v%0d b_rd_data", i), b_rd_data, edat);
        end
        chk("scoreboard drained", DW'(sb.size()), 0);

        // Sustained contention with writes: one grant every cycle, 4/4 split.
        begin
            int ga, gb;
            ga = 0; gb = 0;
            @(posedge clk); #1;
            a_req = 1; a_wr = 1; a_addr = 4'd0; a_din = 32'hA;
            b_req = 1; b_wr = 1; b_addr = 4'd1; b_din = 32'hB;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                chk($sformatf("s%0d one grant", c), DW'(a_gnt + b_gnt), 1);
                chk($sformatf("s%0d grant order", c), DW'(a_gnt), DW'((c % 8) < 4));
                chk($sformatf("s%0d no rd_valid", c), DW'(a_rd_valid | b_rd_valid), 0);
                if (a_gnt) ga++;
                if (b_gnt) gb++;
                @(posedge clk); #1;
            end
            a_req = 0; b_req = 0;
            chk("sustained A grants", DW'(ga), 8);
            chk("sustained B grants", DW'(gb), 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
